// File: rtl/icache_req_gen.sv
// Instruction-cache traffic generator and latency monitor: issues one request at a
// time in a programmed address pattern, checks response addresses, gathers statistics.
module icache_req_gen #(
  parameter int VLEN    = 64,
  parameter int DATA_W  = 32,
  parameter int CNT_W   = 32,
  parameter int LAT_W   = 16,
  parameter int SUM_W   = 48,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [1:0]        mode_i,
  input  logic [VLEN-1:0]   base_addr_i,
  input  logic [15:0]       stride_i,
  input  logic [CNT_W-1:0]  num_req_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              error_o,
  output logic [1:0]        err_code_o,
  output logic              req_o,
  output logic [VLEN-1:0]   req_vaddr_o,
  input  logic              req_ready_i,
  input  logic              rsp_valid_i,
  input  logic [VLEN-1:0]   rsp_vaddr_i,
  input  logic [DATA_W-1:0] rsp_data_i,
  input  logic              miss_i,
  output logic [CNT_W-1:0]  req_cnt_o,
  output logic [CNT_W-1:0]  miss_cnt_o,
  output logic [SUM_W-1:0]  lat_sum_o,
  output logic [LAT_W-1:0]  lat_max_o,
  output logic [DATA_W-1:0] last_data_o,
  output logic [1:0]        state_o
);
  // Request handshake: a request transfers on a clock edge where req_o and req_ready_i
  // are both high; req_o and req_vaddr_o hold stable until then. Responses are only
  // looked at in WAIT, one cycle per rsp_valid_i pulse.

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

  localparam int WC_W = $clog2(TIMEOUT + 1);
  localparam logic [LAT_W-1:0] LAT_SAT = '1;

  state_e            state_q, state_d;
  logic [VLEN-1:0]   addr_q, addr_nxt;
  logic [1:0]        mode_q;
  logic [15:0]       stride_q;
  logic [CNT_W-1:0]  num_q;
  logic [WC_W-1:0]   wait_q;
  logic              start_ok, rsp_ok, rsp_bad, timeout;
  logic [LAT_W-1:0]  lat_val;
  logic [CNT_W-1:0]  req_cnt_nxt;
  logic [SUM_W:0]    sum_ext;

  assign req_o       = (state_q == REQ);
  assign busy_o      = (state_q == REQ) || (state_q == WAIT);
  assign done_o      = (state_q == DONE);
  assign req_vaddr_o = addr_q;
  assign state_o     = state_q;

  always_comb begin
    start_ok = (state_q == IDLE) && start_i;
    rsp_ok   = (state_q == WAIT) && rsp_valid_i && (rsp_vaddr_i == addr_q);
    rsp_bad  = (state_q == WAIT) && rsp_valid_i && (rsp_vaddr_i != addr_q);
    // A response in the timeout cycle takes precedence over the timeout.
    timeout  = (state_q == WAIT) && !rsp_valid_i && (wait_q == WC_W'(TIMEOUT));
    lat_val  = (64'(wait_q) > 64'(LAT_SAT)) ? LAT_SAT : LAT_W'(wait_q);
    req_cnt_nxt = (req_cnt_o == '1) ? req_cnt_o : req_cnt_o + CNT_W'(1);
    sum_ext  = {1'b0, lat_sum_o} + (SUM_W + 1)'(lat_val);
    case (mode_q)
      2'd0:    addr_nxt = addr_q + VLEN'(DATA_W / 8);
      2'd1:    addr_nxt = addr_q + VLEN'(stride_q);
      default: addr_nxt = addr_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start_i) state_d = (mode_i == 2'd3 || num_req_i == '0) ? DONE : REQ;
      REQ:  if (req_ready_i) state_d = WAIT;
      WAIT: begin
        if (rsp_bad || timeout) state_d = DONE;
        else if (rsp_ok)        state_d = (req_cnt_nxt == num_q) ? DONE : REQ;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      mode_q      <= '0;
      stride_q    <= '0;
      num_q       <= '0;
      wait_q      <= '0;
      error_o     <= 1'b0;
      err_code_o  <= 2'd0;
      req_cnt_o   <= '0;
      miss_cnt_o  <= '0;
      lat_sum_o   <= '0;
      lat_max_o   <= '0;
      last_data_o <= '0;
    end else begin
      state_q <= state_d;
      if (start_ok) begin
        addr_q     <= base_addr_i;
        mode_q     <= mode_i;
        stride_q   <= stride_i;
        num_q      <= num_req_i;
        req_cnt_o  <= '0;
        miss_cnt_o <= '0;
        lat_sum_o  <= '0;
        lat_max_o  <= '0;
        err_code_o <= (mode_i == 2'd3) ? 2'd3 : 2'd0;
        error_o    <= (mode_i == 2'd3);
      end
      if (busy_o && miss_i && miss_cnt_o != '1) miss_cnt_o <= miss_cnt_o + CNT_W'(1);
      if (state_q == REQ && req_ready_i) wait_q <= WC_W'(1);
      if (rsp_ok) begin
        req_cnt_o   <= req_cnt_nxt;
        lat_sum_o   <= sum_ext[SUM_W] ? '1 : sum_ext[SUM_W-1:0];
        if (lat_val > lat_max_o) lat_max_o <= lat_val;
        last_data_o <= rsp_data_i;
        addr_q      <= addr_nxt;
      end else if (rsp_bad) begin
        err_code_o <= 2'd1;
        error_o    <= 1'b1;
      end else if (timeout) begin
        err_code_o <= 2'd2;
        error_o    <= 1'b1;
      end else if (state_q == WAIT) begin
        wait_q <= wait_q + WC_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_icache_req_gen.sv
// Directed bench for icache_req_gen: address patterns, latency statistics,
// error paths (mismatch, timeout, illegal mode), wrap and mid-run reset.
module tb_icache_req_gen;
  localparam int VLEN = 64, DATA_W = 32, CNT_W = 32, LAT_W = 16, SUM_W = 48;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic              start_i = 1'b0;
  logic [1:0]        mode_i = '0;
  logic [VLEN-1:0]   base_addr_i = '0;
  logic [15:0]       stride_i = '0;
  logic [CNT_W-1:0]  num_req_i = '0;
  logic              busy_o, done_o, error_o, req_o;
  logic [1:0]        err_code_o, state_o;
  logic [VLEN-1:0]   req_vaddr_o;
  logic              req_ready_i = 1'b0;
  logic              rsp_valid_i = 1'b0;
  logic [VLEN-1:0]   rsp_vaddr_i = '0;
  logic [DATA_W-1:0] rsp_data_i = '0;
  logic              miss_i = 1'b0;
  logic [CNT_W-1:0]  req_cnt_o, miss_cnt_o;
  logic [SUM_W-1:0]  lat_sum_o;
  logic [LAT_W-1:0]  lat_max_o;
  logic [DATA_W-1:0] last_data_o;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int req_hi_cnt = 0;

  icache_req_gen #(.VLEN(VLEN), .DATA_W(DATA_W), .CNT_W(CNT_W), .LAT_W(LAT_W),
                   .SUM_W(SUM_W), .TIMEOUT(16)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .mode_i(mode_i),
    .base_addr_i(base_addr_i), .stride_i(stride_i), .num_req_i(num_req_i),
    .busy_o(busy_o), .done_o(done_o), .error_o(error_o), .err_code_o(err_code_o),
    .req_o(req_o), .req_vaddr_o(req_vaddr_o), .req_ready_i(req_ready_i),
    .rsp_valid_i(rsp_valid_i), .rsp_vaddr_i(rsp_vaddr_i), .rsp_data_i(rsp_data_i),
    .miss_i(miss_i), .req_cnt_o(req_cnt_o), .miss_cnt_o(miss_cnt_o),
    .lat_sum_o(lat_sum_o), .lat_max_o(lat_max_o), .last_data_o(last_data_o),
    .state_o(state_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) begin
    if (done_o) done_cnt++;
    if (req_o)  req_hi_cnt++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic start_run(input logic [1:0] mode, input logic [63:0] base,
                           input logic [15:0] stride, input int num);
    start_i = 1'b1; mode_i = mode; base_addr_i = base; stride_i = stride;
    num_req_i = CNT_W'(num);
    step();
    start_i = 1'b0;
  endtask

  // Waits for a request, accepts it, answers after lat cycles with address addr+off.
  task automatic serve(input int lat, input logic [63:0] off, input logic [31:0] data,
                       input bit miss, output logic [63:0] addr);
    int n = 0;
    while (!req_o && n < 50) begin step(); n++; end
    total++;
    if (!req_o) begin
      bad++;
      $display("FAIL serve_wait_req: req_o=%0b after %0d cycles, required 1", req_o, n);
    end
    addr = req_vaddr_o;
    req_ready_i = 1'b1;
    step();
    req_ready_i = 1'b0;
    for (int i = 1; i < lat; i++) step();
    rsp_valid_i = 1'b1; rsp_vaddr_i = addr + off; rsp_data_i = data; miss_i = miss;
    step();
    rsp_valid_i = 1'b0; miss_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    step(); step();
    total++;
    if ({busy_o, done_o, error_o, req_o, err_code_o} !== 6'b0 || req_vaddr_o !== '0 ||
        req_cnt_o !== '0 || miss_cnt_o !== '0 || lat_sum_o !== '0 || lat_max_o !== '0 ||
        last_data_o !== '0) begin
      bad++;
      $display("FAIL reset_outputs: busy=%0b done=%0b err=%0b code=%0d req=%0b cnt=%0d, required all 0",
               busy_o, done_o, error_o, err_code_o, req_o, req_cnt_o);
    end
    rst_ni = 1'b1;
    step();
  endtask

  task automatic test_sequential();
    logic [63:0] a;
    logic [63:0] exp_a;
    done_cnt = 0;
    start_run(2'd0, 64'h8000_0000, 16'h0, 4);
    for (int i = 0; i < 4; i++) begin
      serve(3, 64'h0, 32'hA000_0000 + i, 1'b0, a);
      exp_a = 64'h8000_0000 + 64'(4 * i);
      total++;
      if (a !== exp_a) begin
        bad++;
        $display("FAIL seq_addr%0d: got %h, required %h", i, a, exp_a);
      end
    end
    total++;
    if (done_o !== 1'b1 || error_o !== 1'b0 || req_cnt_o !== 32'd4 || lat_sum_o !== 48'd12 ||
        lat_max_o !== 16'd3 || last_data_o !== 32'hA000_0003) begin
      bad++;
      $display("FAIL seq_stats: done=%0b err=%0b cnt=%0d sum=%0d max=%0d data=%h, required 1 0 4 12 3 a0000003",
               done_o, error_o, req_cnt_o, lat_sum_o, lat_max_o, last_data_o);
    end
    step();
    total++;
    if (done_o !== 1'b0 || busy_o !== 1'b0 || done_cnt !== 1) begin
      bad++;
      $display("FAIL seq_done_pulse: done=%0b busy=%0b pulses=%0d, required 0 0 1", done_o, busy_o, done_cnt);
    end
  endtask

  task automatic test_stride();
    logic [63:0] a;
    int lats[3] = '{2, 7, 1};
    start_run(2'd1, 64'h1000, 16'h40, 3);
    for (int i = 0; i < 3; i++) begin
      serve(lats[i], 64'h0, 32'hB0 + i, i == 1, a);
      total++;
      if (a !== 64'h1000 + 64'(64 * i)) begin
        bad++;
        $display("FAIL stride_addr%0d: got %h, required %h", i, a, 64'h1000 + 64'(64 * i));
      end
    end
    total++;
    if (lat_sum_o !== 48'd10 || lat_max_o !== 16'd7 || miss_cnt_o !== 32'd1 || req_cnt_o !== 32'd3) begin
      bad++;
      $display("FAIL stride_stats: sum=%0d max=%0d miss=%0d cnt=%0d, required 10 7 1 3",
               lat_sum_o, lat_max_o, miss_cnt_o, req_cnt_o);
    end
    step();
  endtask

  task automatic test_repeat_stall();
    logic [63:0] a;
    int bad_cycles = 0;
    start_run(2'd2, 64'h2000, 16'h0, 2);
    for (int i = 0; i < 5; i++) begin
      // start and a stray response while not in WAIT must both be ignored
      start_i = (i == 1); mode_i = 2'd0; base_addr_i = 64'h9000;
      rsp_valid_i = (i == 2); rsp_vaddr_i = 64'h2000;
      step();
      if (req_o !== 1'b1 || req_vaddr_o !== 64'h2000) bad_cycles++;
    end
    start_i = 1'b0; rsp_valid_i = 1'b0;
    total++;
    if (bad_cycles != 0 || req_cnt_o !== '0) begin
      bad++;
      $display("FAIL stall_stable: unstable cycles=%0d cnt=%0d, required 0 0", bad_cycles, req_cnt_o);
    end
    serve(2, 64'h0, 32'hC1, 1'b0, a);
    serve(1, 64'h0, 32'hC2, 1'b0, a);
    total++;
    if (a !== 64'h2000 || lat_sum_o !== 48'd3 || lat_max_o !== 16'd2 || req_cnt_o !== 32'd2) begin
      bad++;
      $display("FAIL repeat_stats: addr=%h sum=%0d max=%0d cnt=%0d, required 2000 3 2 2",
               a, lat_sum_o, lat_max_o, req_cnt_o);
    end
    step();
  endtask

  task automatic test_addr_mismatch();
    logic [63:0] a;
    done_cnt = 0;
    start_run(2'd0, 64'h3000, 16'h0, 3);
    serve(1, 64'h0, 32'hD1, 1'b0, a);
    serve(2, 64'h4, 32'hD2, 1'b0, a);
    total++;
    if (done_o !== 1'b1 || err_code_o !== 2'd1 || error_o !== 1'b1 || req_cnt_o !== 32'd1 ||
        lat_sum_o !== 48'd1 || last_data_o !== 32'hD1) begin
      bad++;
      $display("FAIL mismatch: done=%0b code=%0d err=%0b cnt=%0d sum=%0d data=%h, required 1 1 1 1 1 d1",
               done_o, err_code_o, error_o, req_cnt_o, lat_sum_o, last_data_o);
    end
    step();
    total++;
    if (done_cnt !== 1 || busy_o !== 1'b0 || error_o !== 1'b1) begin
      bad++;
      $display("FAIL mismatch_end: pulses=%0d busy=%0b err=%0b, required 1 0 1", done_cnt, busy_o, error_o);
    end
  endtask

  task automatic test_timeout();
    logic [63:0] a;
    start_run(2'd0, 64'h4000, 16'h0, 1);
    total++;
    if (error_o !== 1'b0 || err_code_o !== 2'd0) begin
      bad++;
      $display("FAIL start_clears_error: err=%0b code=%0d, required 0 0", error_o, err_code_o);
    end
    req_ready_i = 1'b1;
    step();
    req_ready_i = 1'b0;
    repeat (15) step();
    total++;
    if (busy_o !== 1'b1 || err_code_o !== 2'd0) begin
      bad++;
      $display("FAIL timeout_early: busy=%0b code=%0d at 15 cycles, required 1 0", busy_o, err_code_o);
    end
    step();
    total++;
    if (err_code_o !== 2'd2 || error_o !== 1'b1 || done_o !== 1'b1 || req_cnt_o !== '0) begin
      bad++;
      $display("FAIL timeout_16: code=%0d err=%0b done=%0b cnt=%0d, required 2 1 1 0",
               err_code_o, error_o, done_o, req_cnt_o);
    end
    step();
    start_run(2'd0, 64'h4000, 16'h0, 1);
    serve(16, 64'h0, 32'hE1, 1'b0, a);
    total++;
    if (err_code_o !== 2'd0 || error_o !== 1'b0 || req_cnt_o !== 32'd1 || lat_max_o !== 16'd16 ||
        done_o !== 1'b1) begin
      bad++;
      $display("FAIL timeout_race: code=%0d err=%0b cnt=%0d max=%0d done=%0b, required 0 0 1 16 1",
               err_code_o, error_o, req_cnt_o, lat_max_o, done_o);
    end
    step();
  endtask

  task automatic test_edges();
    logic [63:0] a;
    start_run(2'd3, 64'h5000, 16'h0, 2);
    total++;
    if (done_o !== 1'b1 || err_code_o !== 2'd3 || error_o !== 1'b1 || req_o !== 1'b0) begin
      bad++;
      $display("FAIL illegal_mode: done=%0b code=%0d err=%0b req=%0b, required 1 3 1 0",
               done_o, err_code_o, error_o, req_o);
    end
    step();
    req_hi_cnt = 0;
    start_run(2'd0, 64'h6000, 16'h0, 0);
    total++;
    if (done_o !== 1'b1 || err_code_o !== 2'd0 || error_o !== 1'b0) begin
      bad++;
      $display("FAIL num_zero: done=%0b code=%0d err=%0b, required 1 0 0", done_o, err_code_o, error_o);
    end
    step();
    total++;
    if (req_hi_cnt !== 0) begin
      bad++;
      $display("FAIL num_zero_req: req cycles=%0d, required 0", req_hi_cnt);
    end
    start_run(2'd0, 64'hFFFF_FFFF_FFFF_FFFC, 16'h0, 2);
    serve(1, 64'h0, 32'hF1, 1'b0, a);
    serve(1, 64'h0, 32'hF2, 1'b0, a);
    total++;
    if (a !== 64'h0 || req_cnt_o !== 32'd2 || error_o !== 1'b0) begin
      bad++;
      $display("FAIL wrap: addr=%h cnt=%0d err=%0b, required 0 2 0", a, req_cnt_o, error_o);
    end
    step();
  endtask

  task automatic test_reset_mid_run();
    logic [63:0] a;
    int pulses;
    start_run(2'd0, 64'h7000, 16'h0, 3);
    serve(2, 64'h0, 32'h77, 1'b1, a);
    req_ready_i = 1'b1;
    step();
    req_ready_i = 1'b0;
    step();
    pulses = done_cnt;
    rst_ni = 1'b0;
    step();
    total++;
    if ({busy_o, done_o, error_o, req_o, err_code_o} !== 6'b0 || req_vaddr_o !== '0 ||
        req_cnt_o !== '0 || miss_cnt_o !== '0 || lat_sum_o !== '0 || lat_max_o !== '0 ||
        last_data_o !== '0) begin
      bad++;
      $display("FAIL reset_in_wait: busy=%0b req=%0b cnt=%0d miss=%0d sum=%0d data=%h, required all 0",
               busy_o, req_o, req_cnt_o, miss_cnt_o, lat_sum_o, last_data_o);
    end
    step();
    rst_ni = 1'b1;
    step();
    total++;
    if (done_cnt !== pulses) begin
      bad++;
      $display("FAIL reset_no_done: pulses=%0d, required %0d", done_cnt, pulses);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stride();
    test_repeat_stall();
    test_addr_mismatch();
    test_timeout();
    test_edges();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/icache_req_gen.md
Name: icache_req_gen

Overview:
- Parametrised I$ traffic generator and latency monitor for fetch-path timing characterisation.
- Replaces the frontend in stand-alone cache-subsystem timing harnesses.
- Drives the cache's instruction data-request port with a programmed address pattern, one outstanding request at a time.
- Checks response addresses and accumulates request, miss and latency statistics.

Parameters:
- VLEN, 64, virtual address width.
- DATA_W, 32, fetch data width; must be a power of two, >= 8.
- CNT_W, 32, width of request/miss counters and num_req_i.
- LAT_W, 16, width of per-request latency and lat_max_o.
- SUM_W, 48, width of lat_sum_o.
- TIMEOUT, 1024, max cycles waiting for a response before error.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, synchronous, active-low.
- start_i  in  1  pulse: begin a run (sampled only in IDLE).
- mode_i  in  2  0=sequential, 1=stride, 2=repeat-same, 3=illegal.
- base_addr_i  in  VLEN  first request address.
- stride_i  in  16  byte stride for mode 1, unsigned.
- num_req_i  in  CNT_W  requests in the run.
- busy_o  out  1  run in progress.
- done_o  out  1  one-cycle pulse at run end (success or error).
- error_o  out  1  sticky error flag; cleared by the next accepted start.
- err_code_o  out  2  0=none, 1=addr mismatch, 2=timeout, 3=illegal mode.
- req_o  out  1  request valid.
- req_vaddr_o  out  VLEN  request address.
- req_ready_i  in  1  cache accepts request.
- rsp_valid_i  in  1  response valid.
- rsp_vaddr_i  in  VLEN  response address.
- rsp_data_i  in  DATA_W  response data.
- miss_i  in  1  cache miss indication (pulse).
- req_cnt_o  out  CNT_W  completed requests.
- miss_cnt_o  out  CNT_W  miss_i pulses seen while busy.
- lat_sum_o  out  SUM_W  sum of latencies.
- lat_max_o  out  LAT_W  max latency.
- last_data_o  out  DATA_W  last response data.

Behaviour:
- Reset (rst_ni low at a clock edge): state IDLE. Every output 0, including all counters, err_code_o and last_data_o.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE, start_i=1:
  - clear counters, error_o and err_code_o;
  - load addr=base_addr_i, idx=0;
  - latch mode_i, stride_i and num_req_i for the whole run;
  - mode 3 -> DONE with err_code_o=3;
  - num_req_i=0 -> DONE;
  - otherwise -> REQ.
- start_i while not IDLE is ignored.
- REQ: req_o=1, req_vaddr_o=addr, held stable until accepted. On req_o & req_ready_i -> WAIT, wait counter=1.
- WAIT: req_o=0. On rsp_valid_i:
  - rsp_vaddr_i != issued addr -> err_code_o=1, DONE; no counters updated.
  - match -> req_cnt+1; lat_sum += wait counter; lat_max = max(lat_max, wait counter); last_data_o=rsp_data_i; advance addr.
  - then DONE if req_cnt reaches num_req, else REQ.
- Latency definition: accept at edge t, response sampled at edge t+k -> latency k; minimum is 1.
- rsp_valid_i outside WAIT is ignored.
- Timeout: in WAIT, the wait counter increments each cycle without rsp_valid_i. When it reaches TIMEOUT -> err_code_o=2, DONE.
- Address advance, modulo 2^VLEN (wrap allowed, no error):
  - mode 0: +DATA_W/8;
  - mode 1: +stride;
  - mode 2: unchanged.
- DONE: done_o=1 for one cycle; error_o=(err_code_o!=0); -> IDLE.
- busy_o=1 in REQ and WAIT.
- Counter widths: all counters saturate at all-ones. The latency value fed to lat_sum/lat_max saturates at 2^LAT_W-1.
- miss_cnt increments on miss_i in REQ or WAIT, independent of the response in the same cycle.
- Simultaneous events:
  - rsp_valid_i in the same cycle the wait counter hits TIMEOUT: the response wins.
  - reset mid-run: returns to IDLE, all outputs 0, no done_o pulse.
- Statistics outputs hold their values in IDLE until the next accepted start.

Test Plan:
- Mode 0, base 0x8000_0000, num_req=4, ready always 1, response 3 cycles after accept -> vaddrs 0x8000_0000/04/08/0C; req_cnt=4, lat_sum=12, lat_max=3; done_o one pulse; error_o=0.
- Mode 1, stride 0x40, num_req=3, latencies 2, 7, 1 (miss_i asserted on the second) -> addrs base, +0x40, +0x80; lat_sum=10, lat_max=7, miss_cnt=1.
- Mode 2, req_ready_i low for 5 cycles -> req_o and req_vaddr_o stable throughout; latency counting starts at acceptance only.
- Response rsp_vaddr_i = issued+4 on the 2nd request -> err_code_o=1, error_o=1, req_cnt=1, done_o pulses.
- TIMEOUT=16, no response -> err_code_o=2 exactly 16 cycles after accept; a response arriving in that same cycle instead completes normally.
- Edge cases:
  - mode 3 -> err_code_o=3;
  - num_req=0 -> done_o with no req_o;
  - base 0xFFFF_FFFF_FFFF_FFFC, mode 0 -> second addr 0x0;
  - rst_ni low during WAIT -> all outputs 0 on the next cycle.
